zorro_arbiter: RTL and testbench
================================

ZORRO_ARBITER -- requirements
Module: zorro_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24, SHALL set the C7M cycles a grant may stay unacknowledged before it is withdrawn (legal 2..31).
REQ-002 Parameter HOLDOFF_CYCLES, default 2, SHALL set the idle C7M cycles after master release before new arbitration (legal 0..7).
REQ-003 C7M  input  1  system clock; all state advances on its rising edge.
REQ-004 RESETn  input  1  reset, asynchronous, active-low.
REQ-005 BR  input  [5:1]  slot bus requests, active-low.
REQ-006 BGn  input  1  68000 bus grant, active-low.
REQ-007 BGACKn  input  1  bus-grant-acknowledge from the active master, active-low.
REQ-008 BRn  output  1  combined bus request to 68000, active-low.
REQ-009 BG  output  [5:1]  per-slot grants, active-low, at most one low.
REQ-010 OWNER  output  [2:0]  slot index owning the bus (1..5), 0 when none.
REQ-011 BUSY  output  1  high in any state other than IDLE.
REQ-012 TIMEOUT  output  1  one-cycle pulse on grant withdrawal by timeout.

Function
REQ-013 BR, BGn and BGACKn SHALL pass through 2-flop synchronisers; all decisions below use synchronised values (2-cycle input latency).
REQ-014 States SHALL be IDLE, REQ, GRANT, OWNED, HOLDOFF; all outputs registered.
REQ-015 IDLE: BRn=1, BG=5'b11111, OWNER=0; any synced BR low -> REQ, BRn=0 on the next cycle.
REQ-016 REQ: BRn held 0; all BR high before BGn low -> IDLE with BRn=1.
REQ-017 REQ with BGn low: winner SHALL be chosen from requests asserted in that cycle -> GRANT, BG[winner]=0 next cycle, timeout counter cleared; no request present -> IDLE.
REQ-018 GRANT: BG[winner] held 0, counter increments each cycle; BRn held 0.
REQ-019 GRANT with BGACKn low -> OWNED: BG all high, BRn=1, OWNER=winner, same transition.
REQ-020 GRANT with BR[winner] high and BGACKn high (requester abandoned) -> IDLE, no TIMEOUT pulse.
REQ-021 GRANT with counter reaching TIMEOUT_CYCLES -> IDLE, TIMEOUT=1 for one cycle, BG and BRn released; BGACKn low in the same cycle takes priority (-> OWNED).
REQ-022 OWNED: new requests SHALL be ignored; BGACKn high -> HOLDOFF (OWNER=0), or IDLE directly when HOLDOFF_CYCLES=0.
REQ-023 HOLDOFF: count HOLDOFF_CYCLES cycles with BRn=1, then IDLE.
REQ-024 Fixed priority: slot 1 highest, slot 5 lowest.
REQ-025 BGn rising while in GRANT SHALL be ignored; grant held until acknowledge, abandonment or timeout.

Reset
REQ-026 RESETn low SHALL asynchronously force IDLE, BRn=1, BG=5'b11111, OWNER=0, BUSY=0, TIMEOUT=0, counters 0, synchronisers to inactive (1), round-robin pointer to slot 1, including mid-grant or mid-ownership.
REQ-027 First state change after RESETn rises SHALL need 2 cycles of synchronised request.

Configuration
REQ-028 Macro ZORRO_ROUNDROBIN_EN defined: priority SHALL rotate, search starting at slot after last OWNED winner (5 wraps to 1), pointer updated on entry to OWNED only.
REQ-029 Macro undefined: fixed priority per REQ-024; pointer logic absent.

Structure
REQ-030 Shared package zorro_pkg SHALL hold state encoding, OWNER_NONE=0, slot count 5 and parameter defaults.
REQ-031 Sub-module zorro_sync (parameterised-width 2-flop synchroniser, async reset to 1) SHALL be instantiated once for BR, BGn, BGACKn.

Verification
REQ-032 BR[3]=0, BGn low 4 cycles later, BGACKn low 3 cycles after BG[3] -> BRn=0, BG=5'b11011, then OWNER=3, BG=5'b11111, BRn=1.
REQ-033 BR[2] and BR[4] low together, fixed priority -> BG[2]=0; after release with BR[4] still low -> second grant BG[4]=0 after HOLDOFF 2 cycles.
REQ-034 BR[1] low, BGn low, BGACKn never asserted -> BG[1] released after 24 cycles, TIMEOUT one-cycle pulse, state IDLE then REQ again.
REQ-035 ZORRO_ROUNDROBIN_EN, BR[1] and BR[5] held low continuously -> grants alternate 1,5,1,5.
REQ-036 RESETn low during OWNED (OWNER=4) -> OWNER=0, BG=5'b11111, BRn=1 immediately without clock edge.
REQ-037 BR[5] released during GRANT before BGACKn -> IDLE, TIMEOUT stays 0.

Source files
------------

// File: rtl/zorro_pkg.sv
// Shared definitions for the zorro bus arbiter: state encoding, slot constants,
// parameter defaults and slot-selection helpers.
package zorro_pkg;

    localparam int NUM_SLOTS          = 5;
    localparam int TIMEOUT_CYCLES_DEF = 24;
    localparam int HOLDOFF_CYCLES_DEF = 2;

    localparam logic [2:0] OWNER_NONE = 3'd0;
    localparam logic [2:0] FIRST_SLOT = 3'd1;
    localparam logic [2:0] LAST_SLOT  = 3'd5;
    localparam logic [5:1] BG_IDLE    = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_GRANT   = 3'd2,
        ST_OWNED   = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_e;

    function automatic logic [2:0] next_slot(input logic [2:0] slot);
        return (slot == LAST_SLOT) ? FIRST_SLOT : slot + 3'd1;
    endfunction

    // First requesting slot found when walking upward from start, wrapping 5 -> 1.
    function automatic logic [2:0] pick_winner(input logic [5:1] req, input logic [2:0] start);
        logic [2:0] slot;
        logic [2:0] win;
        win  = OWNER_NONE;
        slot = start;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if ((win == OWNER_NONE) && req[slot]) begin
                win = slot;
            end
            slot = next_slot(slot);
        end
        return win;
    endfunction

    function automatic logic [5:1] grant_mask(input logic [2:0] slot);
        logic [5:1] m;
        m = BG_IDLE;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            if (slot == 3'(i)) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/zorro_if.sv
// Slot-side bus handshake of the zorro arbiter; the arbiter uses the slave
// modport, the bus/CPU side uses the master modport.
interface zorro_if;

    logic [5:1] BR;
    logic       BGn;
    logic       BGACKn;
    logic       BRn;
    logic [5:1] BG;
    logic [2:0] OWNER;
    logic       BUSY;
    logic       TIMEOUT;

    modport master (
        output BR, BGn, BGACKn,
        input  BRn, BG, OWNER, BUSY, TIMEOUT
    );

    modport slave (
        input  BR, BGn, BGACKn,
        output BRn, BG, OWNER, BUSY, TIMEOUT
    );

endinterface

// File: rtl/zorro_sync.sv
// Two-flop synchroniser of configurable width; resets to the inactive (high)
// level because every input it carries is active-low.
module zorro_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability filter: two back-to-back capture stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= '1;
            sync_r <= '1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/zorro_arbiter.sv
// Five-slot bus arbiter in front of a 68000 BR/BG/BGACK handshake.
// Define ZORRO_ROUNDROBIN_EN for rotating priority; default is fixed (slot 1 highest).
module zorro_arbiter
    import zorro_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
    input  logic    C7M,
    input  logic    RESETn,
    zorro_if.slave  bus
);

    localparam logic [4:0] TIMEOUT_LIM = 5'(TIMEOUT_CYCLES);
    localparam logic [2:0] HOLDOFF_LIM = 3'(HOLDOFF_CYCLES);

    logic [6:0] raw_s;
    logic [6:0] sync_s;
    logic [5:1] req_s;
    logic       bgn_low_s;
    logic       bgack_low_s;
    logic       req_any_s;
    logic       winner_held_s;
    logic [2:0] winner_s;
    logic [2:0] search_start_s;
    logic       take_ownership_s;

    state_e     state_r;
    logic [4:0] tcnt_r;
    logic [2:0] hcnt_r;
    logic [2:0] winner_r;
    logic       brn_r;
    logic [5:1] bg_r;
    logic [2:0] owner_r;
    logic       busy_r;
    logic       timeout_r;

    assign raw_s = {bus.BR, bus.BGn, bus.BGACKn};

    zorro_sync #(.WIDTH(7)) u_sync (
        .clk   (C7M),
        .rst_n (RESETn),
        .d     (raw_s),
        .q     (sync_s)
    );

    assign req_s       = ~sync_s[6:2];
    assign bgn_low_s   = ~sync_s[1];
    assign bgack_low_s = ~sync_s[0];

    // Request decode and winner selection from the synchronised request vector.
    always_comb begin
        req_any_s        = |req_s;
        winner_s         = pick_winner(req_s, search_start_s);
        winner_held_s    = req_s[winner_r];
        take_ownership_s = (state_r == ST_GRANT) && bgack_low_s;
    end

`ifdef ZORRO_ROUNDROBIN_EN
    logic [2:0] ptr_r;

    // Rotating search start: one past the slot that most recently took ownership.
    always_ff @(posedge C7M or negedge RESETn) begin
        if (!RESETn) begin
            ptr_r <= FIRST_SLOT;
        end else if (take_ownership_s) begin
            ptr_r <= next_slot(winner_r);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign search_start_s = ptr_r;
`else
    assign search_start_s = FIRST_SLOT;
`endif

    // Arbitration FSM with all bus-facing outputs registered.
    always_ff @(posedge C7M or negedge RESETn) begin
        if (!RESETn) begin
            state_r   <= ST_IDLE;
            tcnt_r    <= 5'd0;
            hcnt_r    <= 3'd0;
            winner_r  <= OWNER_NONE;
            brn_r     <= 1'b1;
            bg_r      <= BG_IDLE;
            owner_r   <= OWNER_NONE;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        state_r <= ST_REQ;
                        brn_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        brn_r   <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (bgn_low_s && req_any_s) begin
                        state_r  <= ST_GRANT;
                        winner_r <= winner_s;
                        bg_r     <= grant_mask(winner_s);
                        tcnt_r   <= 5'd0;
                    end else if (!req_any_s) begin
                        state_r <= ST_IDLE;
                        brn_r   <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_GRANT: begin
                    // Acknowledge wins over both abandonment and timeout; BGn is ignored here.
                    if (bgack_low_s) begin
                        state_r <= ST_OWNED;
                        bg_r    <= BG_IDLE;
                        brn_r   <= 1'b1;
                        owner_r <= winner_r;
                        tcnt_r  <= 5'd0;
                    end else if (!winner_held_s) begin
                        state_r <= ST_IDLE;
                        bg_r    <= BG_IDLE;
                        brn_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        tcnt_r  <= 5'd0;
                    end else if ((tcnt_r + 5'd1) == TIMEOUT_LIM) begin
                        state_r   <= ST_IDLE;
                        bg_r      <= BG_IDLE;
                        brn_r     <= 1'b1;
                        busy_r    <= 1'b0;
                        tcnt_r    <= 5'd0;
                        timeout_r <= 1'b1;
                    end else begin
                        tcnt_r <= tcnt_r + 5'd1;
                    end
                end
                ST_OWNED: begin
                    if (!bgack_low_s) begin
                        owner_r <= OWNER_NONE;
                        hcnt_r  <= 3'd0;
                        if (HOLDOFF_CYCLES == 0) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_HOLDOFF;
                        end
                    end else begin
                        state_r <= ST_OWNED;
                    end
                end
                ST_HOLDOFF: begin
                    if ((hcnt_r + 3'd1) >= HOLDOFF_LIM) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        hcnt_r  <= 3'd0;
                    end else begin
                        hcnt_r <= hcnt_r + 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    bg_r    <= BG_IDLE;
                    brn_r   <= 1'b1;
                    owner_r <= OWNER_NONE;
                    busy_r  <= 1'b0;
                    tcnt_r  <= 5'd0;
                    hcnt_r  <= 3'd0;
                end
            endcase
        end
    end

    assign bus.BRn     = brn_r;
    assign bus.BG      = bg_r;
    assign bus.OWNER   = owner_r;
    assign bus.BUSY    = busy_r;
    assign bus.TIMEOUT = timeout_r;

endmodule

// File: tb/tb_zorro_arbiter.sv
// Randomised scoreboard bench for zorro_arbiter: episodes predict timestamped
// output-change events that a negedge monitor pops and compares.
module tb_zorro_arbiter;
    import zorro_pkg::*;

    localparam int T = TIMEOUT_CYCLES_DEF;
    localparam int H = HOLDOFF_CYCLES_DEF;

    logic C7M = 1'b0;
    logic RESETn;
    zorro_if bus();

    zorro_arbiter #(.TIMEOUT_CYCLES(T), .HOLDOFF_CYCLES(H)) dut (
        .C7M    (C7M),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 C7M = ~C7M;

    int cyc = 0;
    always @(posedge C7M) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [10:0] v;
    } ev_t;

    ev_t         q[$];
    ev_t         mon_e;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    logic [10:0] prev_v;
    logic [10:0] mon_cur;

    logic [5:1]  pend;
    int          r, tg, ta, tr, w, idle_at;
    int          rr_ptr = 1;

    function automatic logic [10:0] vec(logic brn, logic [5:1] bg, logic [2:0] own, logic busy, logic to);
        return {brn, bg, own, busy, to};
    endfunction

    function automatic logic [5:1] oh(int s);
        logic [5:1] m;
        m = 5'b00000;
        m[s] = 1'b1;
        return m;
    endfunction

    // Highest-priority requester when scanning upward from start (5 wraps to 1).
    function automatic int pick(logic [5:1] m, int start);
        for (int k = 0; k < 5; k++) begin
            int s;
            s = ((start - 1 + k) % 5) + 1;
            if (m[s]) return s;
        end
        return 0;
    endfunction

    task automatic push(input int at, input logic [10:0] v);
        ev_t e;
        e.at = at;
        e.v  = v;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", name, act, exp);
        end
    endtask

    // Output-change monitor: every change must match the next predicted event and cycle.
    always @(negedge C7M) begin
        if (mon_en) begin
            mon_cur = vec(bus.BRn, bus.BG, bus.OWNER, bus.BUSY, bus.TIMEOUT);
            if (mon_cur !== prev_v) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL mon_unexpected cyc=%0d got=%b", cyc, mon_cur);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.at != cyc || mon_e.v !== mon_cur) begin
                        bad++;
                        $display("FAIL mon_event got cyc=%0d v=%b exp cyc=%0d v=%b", cyc, mon_cur, mon_e.at, mon_e.v);
                    end
                end
                prev_v = mon_cur;
            end
            while (q.size() > 0 && q[0].at <= cyc) begin
                mon_e = q.pop_front();
                total++;
                bad++;
                $display("FAIL mon_missed cyc=%0d got=%b exp cyc=%0d v=%b", cyc, mon_cur, mon_e.at, mon_e.v);
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge C7M);
            #1;
        end
    endtask

    task automatic start_fresh(input logic [5:1] mask, input int gap);
        goto(((idle_at > cyc) ? idle_at : cyc) + gap);
        bus.BR = ~mask;
        pend   = mask;
        r      = cyc + 3;
        push(r, vec(1'b0, BG_IDLE, 3'd0, 1'b1, 1'b0));
    endtask

    task automatic do_grant(input int d1);
        goto(r + d1);
        bus.BGn = 1'b0;
        tg = cyc + 3;
        w  = pick(pend, rr_ptr);
        push(tg, vec(1'b0, ~oh(w), 3'd0, 1'b1, 1'b0));
    endtask

    task automatic do_ack(input int d2, input int d3, input logic [5:1] newpend);
        goto(tg + d2);
        bus.BGACKn = 1'b0;
        bus.BGn    = 1'b1;
        bus.BR     = ~newpend;
        ta = cyc + 3;
        push(ta, vec(1'b1, BG_IDLE, 3'(w), 1'b1, 1'b0));
`ifdef ZORRO_ROUNDROBIN_EN
        rr_ptr = (w % 5) + 1;
`endif
        goto(ta + d3);
        bus.BGACKn = 1'b1;
        tr   = cyc + 3;
        pend = newpend;
        if (H > 0) push(tr, vec(1'b1, BG_IDLE, 3'd0, 1'b1, 1'b0));
        push(tr + H, vec(1'b1, BG_IDLE, 3'd0, 1'b0, 1'b0));
        idle_at = tr + H;
        if (pend != 5'b00000) begin
            r = tr + H + 1;
            push(r, vec(1'b0, BG_IDLE, 3'd0, 1'b1, 1'b0));
        end
    endtask

    task automatic do_timeout();
        goto(tg + T - 2);
        bus.BGn = 1'b1;
        push(tg + T, vec(1'b1, BG_IDLE, 3'd0, 1'b0, 1'b1));
        push(tg + T + 1, vec(1'b0, BG_IDLE, 3'd0, 1'b1, 1'b0));
        goto(tg + T + 1);
        bus.BR  = 5'b11111;
        pend    = 5'b00000;
        idle_at = cyc + 3;
        push(idle_at, vec(1'b1, BG_IDLE, 3'd0, 1'b0, 1'b0));
    endtask

    task automatic do_abandon(input int d2);
        goto(tg + d2);
        bus.BR  = 5'b11111;
        bus.BGn = 1'b1;
        pend    = 5'b00000;
        idle_at = cyc + 3;
        push(idle_at, vec(1'b1, BG_IDLE, 3'd0, 1'b0, 1'b0));
    endtask

    task automatic do_withdraw(input int d);
        goto(r + d);
        bus.BR  = 5'b11111;
        pend    = 5'b00000;
        idle_at = cyc + 3;
        push(idle_at, vec(1'b1, BG_IDLE, 3'd0, 1'b0, 1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        RESETn     = 1'b0;
        bus.BR     = 5'b11111;
        bus.BGn    = 1'b1;
        bus.BGACKn = 1'b1;
        pend       = 5'b00000;
        idle_at    = 0;
        repeat (3) @(posedge C7M);
        #1;
        chk("reset_outputs", vec(bus.BRn, bus.BG, bus.OWNER, bus.BUSY, bus.TIMEOUT), vec(1'b1, 5'b11111, 3'd0, 1'b0, 1'b0));
        RESETn  = 1'b1;
        idle_at = cyc;
        prev_v  = vec(1'b1, BG_IDLE, 3'd0, 1'b0, 1'b0);
        mon_en  = 1'b1;

        // Single requester, delayed bus grant and acknowledge.
        start_fresh(5'b00100, 0);
        do_grant(1);
        do_ack(3, 2, 5'b00000);

        // Two simultaneous requesters; the loser is served after holdoff.
        start_fresh(5'b01010, 2);
        do_grant(0);
        do_ack(2, 3, 5'b01000);
        do_grant(0);
        do_ack(1, 1, 5'b00000);

        // Grant never acknowledged.
        start_fresh(5'b00001, 1);
        do_grant(2);
        do_timeout();

        // Requester abandons during grant.
        start_fresh(5'b10000, 1);
        do_grant(0);
        do_abandon(4);

        // Two persistent requesters across several ownerships.
        start_fresh(5'b10001, 1);
        for (int i = 0; i < 4; i++) begin
            do_grant(0);
            do_ack(1, 2, (i < 3) ? 5'b10001 : 5'b00000);
        end

        // Requests withdrawn before the CPU grants.
        start_fresh(5'b00110, 0);
        do_withdraw(2);

        for (int i = 0; i < 40; i++) begin
            int         kind;
            logic [5:1] np;
            if (pend == 5'b00000) start_fresh(5'($urandom_range(1, 31)), $urandom_range(0, 3));
            kind = $urandom_range(0, 3);
            if (kind == 3) begin
                do_withdraw($urandom_range(0, 3));
            end else begin
                do_grant($urandom_range(0, 4));
                case (kind)
                    0: begin
                        np = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 31)) : 5'b00000;
                        do_ack($urandom_range(0, T - 3), $urandom_range(0, 4), np);
                    end
                    1: do_timeout();
                    default: do_abandon($urandom_range(0, T - 4));
                endcase
            end
        end
        if (pend != 5'b00000) do_withdraw(0);

        // Asynchronous reset while slot 4 owns the bus.
        start_fresh(5'b01000, 1);
        do_grant(0);
        goto(tg + 1);
        bus.BGACKn = 1'b0;
        bus.BGn    = 1'b1;
        bus.BR     = 5'b11111;
        ta = cyc + 3;
        push(ta, vec(1'b1, BG_IDLE, 3'd4, 1'b1, 1'b0));
        goto(ta + 2);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_pre_reset got=%0d exp=0", q.size());
        end
        mon_en = 1'b0;
        #2;
        RESETn = 1'b0;
        #1;
        chk("async_reset_outputs", vec(bus.BRn, bus.BG, bus.OWNER, bus.BUSY, bus.TIMEOUT), vec(1'b1, 5'b11111, 3'd0, 1'b0, 1'b0));
        bus.BGACKn = 1'b1;
        repeat (2) @(posedge C7M);
        #1;
        RESETn  = 1'b1;
        rr_ptr  = 1;
        pend    = 5'b00000;
        idle_at = cyc;
        prev_v  = vec(1'b1, BG_IDLE, 3'd0, 1'b0, 1'b0);
        mon_en  = 1'b1;

        // Arbitration resumes cleanly after reset.
        start_fresh(5'b00010, 0);
        do_grant(0);
        do_abandon(0);
        goto(idle_at + 2);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_end got=%0d exp=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
